c6_mult_scheduler: RTL and testbench

Shared iterative multiplier with a two-requester round-robin arbiter for the C6 array-multiplier tile. It accepts operand pairs from two independent valid/ready request ports, grants one at a time, and computes the product with a WIDTH-cycle shift-and-add engine. It returns the result with the winning requester's ID on a single valid/ready result port. It sits between the tile's pin-level I/O logic and any on-tile clients needing multiplication.

---
 rtl/c6_mult_scheduler_if.sv | 35 +++
 rtl/c6_mult_scheduler.sv | 133 +++++++++++++
 tb/tb_c6_mult_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/c6_mult_scheduler_if.sv
// Request/result bundle for the shared multiplier: two operand ports and one result port.
// Latency: none, wires only.
// Backpressure: valid/ready on every port; the requester side is master, the multiplier is slave.
interface c6_mult_scheduler_if #(
    parameter int WIDTH = 8
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               res_valid;
    logic               res_ready;
    logic [2*WIDTH-1:0] res_product;
    logic               res_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_product, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_product, res_id
    );
endinterface

// File: rtl/c6_mult_scheduler.sv
// Two-requester round-robin front end feeding one WIDTH-step shift-and-add multiplier.
// Latency: result valid WIDTH cycles after the acceptance edge; one op every WIDTH+2 cycles minimum.
// Backpressure: result held in DONE until res_ready; no request ready outside IDLE.
// Optional C6_SIGNED_EN: two's-complement operands (magnitude multiply, sign fixup on RUN->DONE).
module c6_mult_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    c6_mult_scheduler_if.slave   bus,
    output logic                 busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic               last_grant;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product_q;
    logic               id_q;

    logic               grant0;
    logic               grant1;
    logic               accept;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   acc_next;
    logic [2*WIDTH-1:0] final_p;

`ifdef C6_SIGNED_EN
    logic               neg_q;
`endif

    // Round-robin grant: a lone valid wins; on a tie the requester not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == S_IDLE) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
            grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        end
    end

    assign accept         = grant0 || grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = (state == S_DONE);
    assign bus.res_product = product_q;
    assign bus.res_id     = id_q;
    assign busy           = (state != S_IDLE);

    // Operand selection and the engine datapath: one shift-add step, plus the finished product.
    always_comb begin
        sel_a = grant1 ? bus.req1_a : bus.req0_a;
        sel_b = grant1 ? bus.req1_b : bus.req0_b;
`ifdef C6_SIGNED_EN
        // -2^(WIDTH-1) maps onto itself, which is its correct unsigned magnitude.
        op_a = sel_a[WIDTH-1] ? (~sel_a + 1'b1) : sel_a;
        op_b = sel_b[WIDTH-1] ? (~sel_b + 1'b1) : sel_b;
`else
        op_a = sel_a;
        op_b = sel_b;
`endif
        upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        acc_next  = {upper_sum, acc[WIDTH-1:0]} >> 1;
`ifdef C6_SIGNED_EN
        final_p = neg_q ? (~acc_next[2*WIDTH-1:0] + 1'b1) : acc_next[2*WIDTH-1:0];
`else
        final_p = acc_next[2*WIDTH-1:0];
`endif
    end

    // Control FSM, pointer and engine registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            product_q  <= '0;
            id_q       <= 1'b0;
`ifdef C6_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_RUN;
                        last_grant <= grant1;
                        id_q       <= grant1;
                        acc        <= '0;
                        mcand      <= op_a;
                        mplier     <= op_b;
                        cnt        <= '0;
`ifdef C6_SIGNED_EN
                        neg_q      <= sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= S_DONE;
                        product_q <= final_p;
                        cnt       <= '0;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_c6_mult_scheduler.sv
// Bench for c6_mult_scheduler: directed test-plan steps followed by randomized operations.
// Latency: checks result at exactly WIDTH cycles after acceptance.
// Backpressure: exercises held results and checks readies stay low in DONE.
module tb_c6_mult_scheduler;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    logic busy;

    int vectors;
    int miscompares;
    bit ptr;   // requester granted last, per the arbitration rule

    c6_mult_scheduler_if #(.WIDTH(WIDTH)) bus ();

    c6_mult_scheduler #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product from the operand values.
    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int pa, pb;
`ifdef C6_SIGNED_EN
        pa = (a >= 128) ? int'(a) - 256 : int'(a);
        pb = (b >= 128) ? int'(b) - 256 : int'(b);
`else
        pa = int'(a);
        pb = int'(b);
`endif
        return 16'(pa * pb);
    endfunction

    // Serve one transaction from the currently driven valids; caller is in IDLE, #1 after an edge.
    task automatic serve(input int hold);
        int exp_id;
        int lat;
        logic [2*WIDTH-1:0] exp_p;
        logic [2*WIDTH-1:0] held_p;
        logic held_id;
        bus.res_ready = (hold == 0);
        #1;
        if (bus.req0_valid && bus.req1_valid) exp_id = ptr ? 0 : 1;
        else exp_id = bus.req1_valid ? 1 : 0;
        chk("req0_ready", 32'(bus.req0_ready), 32'(exp_id == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(exp_id == 1));
        exp_p = (exp_id == 0) ? ref_mul(bus.req0_a, bus.req0_b) : ref_mul(bus.req1_a, bus.req1_b);
        ptr = (exp_id == 1);
        @(posedge clk); #1;
        if (exp_id == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);
        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(WIDTH));
        chk("product", 32'(bus.res_product), 32'(exp_p));
        chk("res_id", 32'(bus.res_id), 32'(exp_id));
        if (hold > 0) begin
            held_p  = bus.res_product;
            held_id = bus.res_id;
            for (int i = 1; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(bus.res_valid), 32'd1);
                chk("hold_product", 32'(bus.res_product), 32'(exp_p));
                chk("hold_id", 32'(bus.res_id), 32'(held_id));
                chk("hold_readies", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            end
            chk("hold_product_final", 32'(bus.res_product), 32'(held_p));
            bus.res_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("res_valid_after_hs", 32'(bus.res_valid), 32'd0);
        chk("busy_after_hs", 32'(busy), 32'd0);
    endtask

    task automatic drain(input int hold);
        int guard;
        guard = 0;
        while ((bus.req0_valid || bus.req1_valid) && guard < 4) begin
            serve(hold);
            guard++;
        end
    endtask

    task automatic set_req(input int port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (port == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    initial begin
        bit seen;
        vectors     = 0;
        miscompares = 0;
        ptr         = 1'b1;
        rst         = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready  = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(bus.res_product), 32'd0);
        chk("rst_id", 32'(bus.res_id), 32'd0);
        chk("rst_readies", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned basic 0xFF x 0xFF on requester 0.
        set_req(0, 8'hFF, 8'hFF);
        serve(0);

        // Tie after reset, then three alternating ties.
        set_req(0, 8'd3, 8'd5);
        set_req(1, 8'd7, 8'd9);
        serve(0);
        serve(0);
        set_req(0, 8'd11, 8'd13);
        set_req(1, 8'd17, 8'd19);
        serve(0);
        set_req(0, 8'd23, 8'd29);
        serve(0);
        set_req(1, 8'd31, 8'd37);
        serve(0);
        drain(0);

        // Backpressure for 5 cycles with the other requester waiting.
        set_req(1, 8'hC3, 8'h5A);
        set_req(0, 8'h12, 8'h34);
        serve(5);
        drain(0);

        // Reset in the middle of RUN.
        set_req(0, 8'h44, 8'h55);
        set_req(1, 8'h66, 8'h77);
        #1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrun_res_valid", 32'(bus.res_valid), 32'd0);
        chk("midrun_busy", 32'(busy), 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen = 1'b1;
        end
        chk("midrun_no_result", 32'(seen), 32'd0);
        set_req(0, 8'h21, 8'h43);
        set_req(1, 8'h65, 8'h87);
        serve(0);
        drain(0);

        // Zero operand and the most-negative operand cases.
        set_req(0, 8'h00, 8'hAB);
        serve(0);
        set_req(1, 8'h80, 8'hFF);
        serve(0);
        set_req(0, 8'h80, 8'h80);
        serve(0);

        // Randomized operations with random request patterns and result backpressure.
        for (int n = 0; n < 16; n++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            if (v0) set_req(0, 8'($urandom), 8'($urandom));
            if (v1) set_req(1, 8'($urandom), 8'($urandom));
            drain(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
